// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: ALUControl encodings, ALUop codes, M-extension funct3 codes and MDU state enum
package rv_alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_MDU  = 4'b1111
  } alu_ctrl_e;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
  typedef enum logic [2:0] {
    F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  } mext_f3_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} mdu_state_e;
endpackage

// File: rtl/alu_decoder_mdu_if.sv
// alu_decoder_mdu_if: decoder/MDU bus between the core (master) and the ALU decoder (slave)
//   core -> decoder: ALUop, op5, funct3, funct7, kill, srcA, srcB
//   decoder -> core: ALUControl, mdu_sel, stall, mdu_result, mdu_done
interface alu_decoder_mdu_if #(parameter int XLEN = 32);
  logic [1:0]      ALUop;
  logic            op5;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            kill;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [3:0]      ALUControl;
  logic            mdu_sel;
  logic            stall;
  logic [XLEN-1:0] mdu_result;
  logic            mdu_done;
  modport master (
    output ALUop, op5, funct3, funct7, kill, srcA, srcB,
    input  ALUControl, mdu_sel, stall, mdu_result, mdu_done
  );
  modport slave (
    input  ALUop, op5, funct3, funct7, kill, srcA, srcB,
    output ALUControl, mdu_sel, stall, mdu_result, mdu_done
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
//   clk, rst (async, active-high); start/kill/funct3/a/b in; done (1-cycle strobe), result out
module mdu_iter
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_e        state, state_n;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [XLEN-1:0]   opnd, dres, abs_a, abs_b, special_res;
  logic [XLEN:0]     t;
  logic [2:0]        op;
  logic              neg, is_div, sign_a, sign_b, special, last;
  assign is_div = funct3[2];
  // Signed operands: DIV/REM (funct3[0]=0) both; MULH both; MULHSU only a.
  assign sign_a = a[XLEN-1] & (is_div ? ~funct3[0] : (funct3 == F3_MULH || funct3 == F3_MULHSU));
  assign sign_b = b[XLEN-1] & (is_div ? ~funct3[0] : (funct3 == F3_MULH));
  assign abs_a = sign_a ? -a : a;
  assign abs_b = sign_b ? -b : b;
  assign special = is_div & ((b == '0) | (~funct3[0] & (a == MIN_INT) & (b == '1)));
  assign special_res = (b == '0) ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : MIN_INT);
  assign last = count == CW'(STEPS - 1);
  assign done = state == S_DONE;
  assign prod = neg ? -acc : acc;
  assign dres = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? (special ? S_DONE : S_CALC) : S_IDLE;
      S_CALC:  state_n = last ? S_FIX : S_CALC;
      S_FIX:   state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end
  // acc holds {hi, lo}: multiply keeps {partial, multiplier}, divide keeps {remainder, dividend/quotient}.
  always_comb begin
    acc_n = acc;
    t = '0;
    for (int i = 0; i < UNROLL; i++) begin
      t = op[2] ? acc_n[2*XLEN-1:XLEN-1] - {1'b0, opnd}
                : {1'b0, acc_n[2*XLEN-1:XLEN]} + (acc_n[0] ? {1'b0, opnd} : '0);
      acc_n = op[2] ? (t[XLEN] ? {acc_n[2*XLEN-2:0], 1'b0} : {t[XLEN-1:0], acc_n[XLEN-2:0], 1'b1})
                    : {t, acc_n[XLEN-1:1]};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      op     <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (state == S_IDLE && state_n != S_IDLE) begin
      op    <= funct3;
      neg   <= (funct3 == F3_REM) ? sign_a : sign_a ^ sign_b;
      count <= '0;
      acc   <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
      opnd  <= is_div ? abs_b : abs_a;
      if (special) result <= special_res;
    end else if (state == S_CALC) begin
      acc   <= acc_n;
      count <= count + 1'b1;
    end else if (state == S_FIX && !kill) begin
      result <= op[2] ? (neg ? -dres : dres)
                      : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
endmodule

// File: rtl/alu_decoder_mdu.sv
// alu_decoder_mdu: RV32IM ALU decoder with iterative multiply/divide unit and core stall
//   clk, rst (async, active-high); bus: alu_decoder_mdu_if slave (decode inputs, operands, kill in;
//   ALUControl, mdu_sel, stall, mdu_result, mdu_done out)
module alu_decoder_mdu
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic              clk,
  input logic              rst,
  alu_decoder_mdu_if.slave bus
);
  logic      mdu_req;
  alu_ctrl_e rtype;
  assign mdu_req = (bus.ALUop == ALUOP_RTYPE) & bus.op5 & (bus.funct7 == FUNCT7_MEXT);
  always_comb begin
    rtype = ALU_ADD;
    case (bus.funct3)
      3'b000:  rtype = (bus.op5 & bus.funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  rtype = ALU_SLL;
      3'b010:  rtype = ALU_SLT;
      3'b011:  rtype = ALU_SLTU;
      3'b100:  rtype = ALU_XOR;
      3'b101:  rtype = bus.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  rtype = ALU_OR;
      default: rtype = ALU_AND;
    endcase
  end
  assign bus.ALUControl = mdu_req ? ALU_MDU
                        : bus.ALUop == ALUOP_RTYPE ? rtype
                        : bus.ALUop == ALUOP_SUB ? ALU_SUB : ALU_ADD;
  assign bus.mdu_sel = mdu_req;
  assign bus.stall = mdu_req & ~bus.mdu_done;
  mdu_iter #(.XLEN(XLEN), .UNROLL(UNROLL)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_req),
    .kill   (bus.kill),
    .funct3 (bus.funct3),
    .a      (bus.srcA),
    .b      (bus.srcB),
    .done   (bus.mdu_done),
    .result (bus.mdu_result)
  );
endmodule

// File: tb/tb_alu_decoder_mdu.sv
// tb_alu_decoder_mdu: randomized self-checking bench for alu_decoder_mdu (UNROLL=1 and UNROLL=4)
module tb_alu_decoder_mdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_decoder_mdu_if #(.XLEN(32)) bus0 ();
  alu_decoder_mdu_if #(.XLEN(32)) bus1 ();
  alu_decoder_mdu #(.XLEN(32), .UNROLL(1)) dut  (.clk(clk), .rst(rst), .bus(bus0));
  alu_decoder_mdu #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus1));
  logic [1:0]  aluop [2];
  logic        op5   [2];
  logic [2:0]  f3    [2];
  logic [6:0]  f7    [2];
  logic        kill  [2];
  logic [31:0] sa    [2];
  logic [31:0] sb    [2];
  logic [3:0]  ctrl  [2];
  logic        sel   [2];
  logic        stl   [2];
  logic        dn    [2];
  logic [31:0] res   [2];
  assign bus0.ALUop = aluop[0];
  assign bus0.op5 = op5[0];
  assign bus0.funct3 = f3[0];
  assign bus0.funct7 = f7[0];
  assign bus0.kill = kill[0];
  assign bus0.srcA = sa[0];
  assign bus0.srcB = sb[0];
  assign bus1.ALUop = aluop[1];
  assign bus1.op5 = op5[1];
  assign bus1.funct3 = f3[1];
  assign bus1.funct7 = f7[1];
  assign bus1.kill = kill[1];
  assign bus1.srcA = sa[1];
  assign bus1.srcB = sb[1];
  assign ctrl[0] = bus0.ALUControl;
  assign sel[0] = bus0.mdu_sel;
  assign stl[0] = bus0.stall;
  assign dn[0] = bus0.mdu_done;
  assign res[0] = bus0.mdu_result;
  assign ctrl[1] = bus1.ALUControl;
  assign sel[1] = bus1.mdu_sel;
  assign stl[1] = bus1.stall;
  assign dn[1] = bus1.mdu_done;
  assign res[1] = bus1.mdu_result;
  int checks = 0;
  int passes = 0;
  localparam logic [31:0] MIN = 32'h8000_0000;
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic o5, input logic [2:0] fn3,
                                         input logic [6:0] fn7);
    if (op == 2'b10 && o5 && fn7 == 7'b0000001) return 4'hF;
    if (op == 2'b01) return 4'h1;
    if (op != 2'b10) return 4'h0;
    case (fn3)
      3'd0: return (o5 && fn7[5]) ? 4'h1 : 4'h0;
      3'd1: return 4'h7;
      3'd2: return 4'h5;
      3'd3: return 4'h6;
      3'd4: return 4'h4;
      3'd5: return fn7[5] ? 4'h9 : 4'h8;
      3'd6: return 4'h3;
      default: return 4'h2;
    endcase
  endfunction
  function automatic logic [31:0] ref_mdu(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    logic signed [31:0] sq, sr;
    logic ovf;
    ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
    sq = 0;
    sr = 0;
    if (b != 0 && !ovf) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
    end
    up = {32'b0, a} * {32'b0, b};
    case (fn3)
      3'd0: return up[31:0];
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN : sq;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : sr;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic int ref_lat(input int u, input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b);
    if (fn3[2] && (b == 0 || (!fn3[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
    return (u == 1 ? 8 : 32) + 2;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int u);
    aluop[u] = 2'b00;
    step();
  endtask
  task automatic run_mdu(input int u, input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int extra, input bit drop, input string nm);
    int n = 0;
    int lat;
    lat = ref_lat(u, fn3, a, b) + extra;
    aluop[u] = 2'b10; op5[u] = 1'b1; f3[u] = fn3; f7[u] = 7'h01; sa[u] = a; sb[u] = b;
    #1;
    checks++;
    if (ctrl[u] !== 4'hF || sel[u] !== 1'b1)
      $display("FAIL %s u%0d decode: ctrl=%h sel=%b, want F/1", nm, u, ctrl[u], sel[u]);
    else passes++;
    if (extra != 0) begin step(); n = 1; end
    while (!dn[u] && n < 80) begin
      if (!drop) begin
        checks++;
        if (stl[u] !== 1'b1) $display("FAIL %s u%0d stall at cycle %0d: got %b want 1", nm, u, n - extra, stl[u]);
        else passes++;
      end
      step();
      n++;
      if (n > extra) begin sa[u] = $urandom; sb[u] = $urandom; end
      if (drop && n == 3) aluop[u] = 2'b00;
    end
    checks++;
    if (n !== lat) $display("FAIL %s u%0d latency: got %0d want %0d", nm, u, n, lat);
    else passes++;
    checks++;
    if (res[u] !== exp_res) $display("FAIL %s u%0d result: got %h want %h", nm, u, res[u], exp_res);
    else passes++;
    checks++;
    if (stl[u] !== 1'b0) $display("FAIL %s u%0d stall at done: got %b want 0", nm, u, stl[u]);
    else passes++;
  endtask
  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      aluop[u] = 0; op5[u] = 0; f3[u] = 0; f7[u] = 0; kill[u] = 0; sa[u] = 0; sb[u] = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (res[u] !== 32'h0 || dn[u] !== 1'b0 || stl[u] !== 1'b0 || ctrl[u] !== 4'h0)
        $display("FAIL reset u%0d: res=%h done=%b stall=%b ctrl=%h, want 0/0/0/0", u, res[u], dn[u], stl[u], ctrl[u]);
      else passes++;
    end
  endtask
  task automatic test_decode();
    logic [6:0] fv;
    logic [3:0] e;
    kill[0] = 1'b1;
    for (int op = 0; op < 4; op++)
      for (int fn = 0; fn < 8; fn++)
        for (int o = 0; o < 2; o++)
          for (int j = 0; j < 4; j++) begin
            fv = j == 0 ? 7'h00 : j == 1 ? 7'h20 : j == 2 ? 7'h01 : 7'($urandom);
            aluop[0] = 2'(op); f3[0] = 3'(fn); op5[0] = 1'(o); f7[0] = fv;
            #1;
            e = ref_ctrl(2'(op), 1'(o), 3'(fn), fv);
            checks++;
            if (ctrl[0] !== e || sel[0] !== (e == 4'hF) || stl[0] !== (e == 4'hF))
              $display("FAIL decode op=%0d f3=%0d op5=%0d f7=%h: ctrl=%h sel=%b stall=%b want ctrl=%h",
                       op, fn, o, fv, ctrl[0], sel[0], stl[0], e);
            else passes++;
          end
    kill[0] = 1'b0;
    idle(0);
  endtask
  task automatic test_mul(input int u);
    run_mdu(u, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, "mul"); idle(u);
    run_mdu(u, 3'd1, MIN, MIN, 32'h4000_0000, 0, 0, "mulh"); idle(u);
    run_mdu(u, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'h1, 0, 0, "mulhu"); idle(u);
  endtask
  task automatic test_div_special(input int u);
    run_mdu(u, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, "div0"); idle(u);
    run_mdu(u, 3'd7, 32'd5, 32'd0, 32'd5, 0, 0, "remu0"); idle(u);
    run_mdu(u, 3'd4, MIN, 32'hFFFF_FFFF, MIN, 0, 0, "div_ovf"); idle(u);
    run_mdu(u, 3'd6, MIN, 32'hFFFF_FFFF, 32'h0, 0, 0, "rem_ovf"); idle(u);
  endtask
  task automatic test_back_to_back(input int u);
    run_mdu(u, 3'd5, 32'd100, 32'd7, 32'd14, 0, 0, "divu");
    run_mdu(u, 3'd6, -32'sd100, 32'd7, 32'hFFFF_FFFE, 1, 0, "rem_b2b");
    idle(u);
  endtask
  task automatic test_req_drop(input int u);
    run_mdu(u, 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, ref_mdu(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF), 0, 1, "mulhsu_drop");
    idle(u);
  endtask
  task automatic test_kill(input int u);
    int seen = 0;
    aluop[u] = 2'b10; op5[u] = 1'b1; f3[u] = 3'd0; f7[u] = 7'h01; sa[u] = 32'd123; sb[u] = 32'd456;
    repeat (u == 1 ? 5 : 10) step();
    kill[u] = 1'b1;
    aluop[u] = 2'b00;
    step();
    kill[u] = 1'b0;
    repeat (40) begin
      if (dn[u]) seen++;
      step();
    end
    checks++;
    if (seen !== 0) $display("FAIL kill u%0d: mdu_done seen %0d times, want 0", u, seen);
    else passes++;
    run_mdu(u, 3'd0, 32'd6, 32'd7, 32'd42, 0, 0, "after_kill");
    idle(u);
  endtask
  task automatic test_rst_mid();
    for (int u = 0; u < 2; u++) begin
      aluop[u] = 2'b10; op5[u] = 1'b1; f3[u] = 3'd0; f7[u] = 7'h01; sa[u] = 32'd9; sb[u] = 32'd9;
    end
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (res[u] !== 32'h0 || dn[u] !== 1'b0) $display("FAIL rst_mid u%0d: res=%h done=%b want 0/0", u, res[u], dn[u]);
      else passes++;
    end
    #1 rst = 1'b0;
    aluop[0] = 2'b00;
    aluop[1] = 2'b00;
    step();
    run_mdu(0, 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 0, "after_rst"); idle(0);
    run_mdu(1, 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 0, "after_rst"); idle(1);
  endtask
  task automatic test_random(input int u);
    logic [2:0] fn3;
    logic [31:0] a, b;
    for (int i = 0; i < 14; i++) begin
      fn3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? MIN : 32'($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 9));
      run_mdu(u, fn3, a, b, ref_mdu(fn3, a, b), 0, 0, "rand");
      idle(u);
    end
  endtask
  initial begin
    test_reset();
    test_decode();
    for (int u = 0; u < 2; u++) begin
      test_mul(u);
      test_div_special(u);
      test_back_to_back(u);
      test_req_drop(u);
      test_kill(u);
    end
    test_rst_mid();
    for (int u = 0; u < 2; u++) test_random(u);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
